regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 32x64 register file.
- Shares the register file's single write port (regWr / write address / write_data) between two requesters: A = ALU result, B = load unit.
- Each requester uses a valid/ready handshake with round-robin priority.
- Tracks in-flight destination registers so the decode stage can stall on read-after-write hazards.

Parameters:
- XLEN, 64, data width of the write port.
- AW, 5, register address width.
- NREG, 32, number of registers (= 2**AW).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_stall  in  1  when high, no grants are issued.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A accepted this cycle.
- a_rd  in  AW  A destination register.
- a_data  in  XLEN  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B accepted this cycle.
- b_rd  in  AW  B destination register.
- b_data  in  XLEN  B write data.
- rf_regWr  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- claim_valid  in  1  issue stage reserves a destination register.
- claim_rd  in  AW  register being reserved.
- rd_addr_one  in  AW  decode read address, port one.
- rd_addr_two  in  AW  decode read address, port two.
- busy_one  out  1  rd_addr_one has a pending write.
- busy_two  out  1  rd_addr_two has a pending write.
- byp_hit_one  out  1  bypass valid, port one (optional feature).
- byp_hit_two  out  1  bypass valid, port two (optional feature).
- byp_data_one  out  XLEN  bypass data, port one.
- byp_data_two  out  XLEN  bypass data, port two.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_regWr, rf_waddr, rf_wdata = 0.
  - pending[NREG-1:0] = 0.
  - prio = A.
  - All byp_* = 0.
  - a_ready and b_ready are forced 0 while reset is held.
- Reset mid-operation: an accepted but uncommitted write is dropped; all reservations are cleared.
- Grant (combinational, one grant per cycle):
  - With wb_stall = 1, both readies are 0.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by prio is granted.
  - prio flips to the non-granted requester on every cycle in which both were valid. It is unchanged otherwise.
  - a_ready / b_ready depend only on valid, prio and wb_stall, never on data.
- Handshake: transfer when valid && ready at a rising edge. Requesters hold rd and data stable while valid && !ready.
- Commit latency:
  - Transfer at edge N: rf_regWr = 1 with captured rd and data during cycle N+1. The register file writes at edge N+1.
  - rf_regWr returns to 0 after one cycle unless a new transfer occurred at edge N+1. Back-to-back, one write per cycle, no bubbles.
- x0: a transfer with rd = 0 is accepted (ready asserted) but rf_regWr stays 0. The pending bit is untouched.
- Scoreboard:
  - claim_valid with claim_rd != 0 sets pending[claim_rd] at the edge. A claim on rd = 0 is ignored.
  - A commit (rf_regWr = 1) clears pending[rf_waddr] at the edge ending that cycle.
  - Claim and commit to the same register in the same cycle: the bit stays set (claim wins).
  - A claim on an already-pending register leaves the bit set.
  - A commit to a non-pending register writes normally and clears nothing.
- Busy outputs:
  - busy_one = pending[rd_addr_one], combinational. Same rule for busy_two.
  - Address 0 always reads busy = 0.
- Width: addresses compare at full AW bits. No arithmetic on data.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - byp_hit_one = rf_regWr && rf_waddr == rd_addr_one && rd_addr_one != 0.
  - byp_data_one = rf_wdata when hit, else 0. Same rules for port two.
  - busy_one is masked to 0 when byp_hit_one = 1, because the data is forwarded in the same cycle.
- Undefined: byp_hit_* and byp_data_* are tied to 0. Busy is unmasked, so the decode stage waits one cycle longer for the register file write.

Test Plan:
- Reset: rst_n low mid-transfer (a_valid = 1, a_rd = 2) -> rf_regWr = 0 immediately; pending = 0; a_ready = 0 until release.
- Single write: a_valid = 1, a_rd = 2, a_data = 2500 -> a_ready = 1; next cycle rf_regWr = 1, rf_waddr = 2, rf_wdata = 2500; then 0.
- Contention: a_valid and b_valid held for 4 cycles with a_rd = 19, a_data = 2555 and b_rd = 31, b_data = 2555 -> grants A, B, A, B; rf_regWr high 4 consecutive cycles.
- Scoreboard: claim rd = 19 -> busy_one = 1 with rd_addr_one = 19. B writes rd = 19 -> busy_one drops after the commit edge. Claim and commit to 19 in the same cycle -> busy stays 1.
- x0 and stall: a_rd = 0, data = 0xFFFF -> accepted, rf_regWr stays 0. wb_stall = 1 with both valid -> no readies, prio unchanged.
- Bypass (RF_WB_BYPASS_EN): commit to rd = 31 with data 2555 while rd_addr_one = 31 and rd_addr_two = 2 -> byp_hit_one = 1, byp_data_one = 2555, busy_one = 0; byp_hit_two = 0. Without the macro -> byp_hit_one = 0, busy_one = 1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Requester handshakes and register-file write port of the
//               write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            wb_stall;
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
    logic            rf_regWr;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport master (
        output wb_stall, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, rf_regWr, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_stall, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, rf_regWr, rf_waddr, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter for the 32x64 register file
//               with a pending-write scoreboard for RAW hazard stalls.
//               Optional same-cycle bypass enabled by macro RF_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    regfile_wb_arbiter_if.slave  bus,
    input  wire logic            claim_valid,
    input  wire logic [AW-1:0]   claim_rd,
    input  wire logic [AW-1:0]   rd_addr_one,
    input  wire logic [AW-1:0]   rd_addr_two,
    output logic                 busy_one,
    output logic                 busy_two,
    output logic                 byp_hit_one,
    output logic                 byp_hit_two,
    output logic [XLEN-1:0]      byp_data_one,
    output logic [XLEN-1:0]      byp_data_two
);

    localparam logic [AW-1:0] c_X0 = '0;

    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t           r_prio;
    prio_t           w_prio_nxt;
    logic            w_grant_a;
    logic            w_grant_b;

    logic            r_rf_regWr;
    logic [AW-1:0]   r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic            w_busy_raw_one;
    logic            w_busy_raw_two;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_A;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // Readies depend only on valid, priority, stall and reset - never on data.
    always_comb begin
        w_prio_nxt = r_prio;
        w_grant_a  = 1'b0;
        w_grant_b  = 1'b0;
        if (rst_n && !bus.wb_stall) begin
            if (bus.a_valid && bus.b_valid) begin
                if (r_prio == PRIO_A) begin
                    w_grant_a  = 1'b1;
                    w_prio_nxt = PRIO_B;
                end else begin
                    w_grant_b  = 1'b1;
                    w_prio_nxt = PRIO_A;
                end
            end else begin
                w_grant_a = bus.a_valid;
                w_grant_b = bus.b_valid;
            end
        end
    end

    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_regWr <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_regWr <= 1'b0;
            if (w_grant_a && (bus.a_rd != c_X0)) begin
                r_rf_regWr <= 1'b1;
                r_rf_waddr <= bus.a_rd;
                r_rf_wdata <= bus.a_data;
            end else if (w_grant_b && (bus.b_rd != c_X0)) begin
                r_rf_regWr <= 1'b1;
                r_rf_waddr <= bus.b_rd;
                r_rf_wdata <= bus.b_data;
            end
        end
    end

    assign bus.rf_regWr = r_rf_regWr;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;

    // Claim is applied after the commit clear so a same-cycle claim wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_rf_regWr) begin
            w_pending_nxt[r_rf_waddr] = 1'b0;
        end
        if (claim_valid && (claim_rd != c_X0)) begin
            w_pending_nxt[claim_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign w_busy_raw_one = (rd_addr_one != c_X0) && r_pending[rd_addr_one];
    assign w_busy_raw_two = (rd_addr_two != c_X0) && r_pending[rd_addr_two];

`ifdef RF_WB_BYPASS_EN
    logic w_hit_one;
    logic w_hit_two;

    assign w_hit_one    = r_rf_regWr && (r_rf_waddr == rd_addr_one) && (rd_addr_one != c_X0);
    assign w_hit_two    = r_rf_regWr && (r_rf_waddr == rd_addr_two) && (rd_addr_two != c_X0);
    assign byp_hit_one  = w_hit_one;
    assign byp_hit_two  = w_hit_two;
    assign byp_data_one = w_hit_one ? r_rf_wdata : '0;
    assign byp_data_two = w_hit_two ? r_rf_wdata : '0;
    // Forwarded data satisfies the reader this cycle, so it need not stall.
    assign busy_one     = w_busy_raw_one && !w_hit_one;
    assign busy_two     = w_busy_raw_two && !w_hit_two;
`else
    assign byp_hit_one  = 1'b0;
    assign byp_hit_two  = 1'b0;
    assign byp_data_one = '0;
    assign byp_data_two = '0;
    assign busy_one     = w_busy_raw_one;
    assign busy_two     = w_busy_raw_two;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed scoreboard bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk;
    logic            rst_n;
    logic            claim_valid;
    logic [AW-1:0]   claim_rd;
    logic [AW-1:0]   rd_addr_one;
    logic [AW-1:0]   rd_addr_two;
    logic            busy_one;
    logic            busy_two;
    logic            byp_hit_one;
    logic            byp_hit_two;
    logic [XLEN-1:0] byp_data_one;
    logic [XLEN-1:0] byp_data_two;

    int vectors    = 0;
    int miscompares = 0;
    wr_t exp_q[$];

`ifdef RF_WB_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .claim_valid  (claim_valid),
        .claim_rd     (claim_rd),
        .rd_addr_one  (rd_addr_one),
        .rd_addr_two  (rd_addr_two),
        .busy_one     (busy_one),
        .busy_two     (busy_two),
        .byp_hit_one  (byp_hit_one),
        .byp_hit_two  (byp_hit_two),
        .byp_data_one (byp_data_one),
        .byp_data_two (byp_data_two)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        if (rd != '0) exp_q.push_back('{rd: rd, data: data});
    endtask

    // Monitor: every commit must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.rf_regWr === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_commit: waddr %0d wdata %0h, none expected", bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("commit_waddr", 64'(bus.rf_waddr), 64'(e.rd));
                chk("commit_wdata", bus.rf_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.wb_stall = 1'b0;
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        claim_valid = 1'b0; claim_rd = '0;
        rd_addr_one = 5'd2; rd_addr_two = 5'd0;

        // Reset state with a request held
        bus.a_valid = 1'b1; bus.a_rd = 5'd2; bus.a_data = 64'd2500;
        step();
        @(negedge clk);
        chk("rst_a_ready", 64'(bus.a_ready), 0);
        chk("rst_regWr", 64'(bus.rf_regWr), 0);
        chk("rst_waddr", 64'(bus.rf_waddr), 0);
        chk("rst_busy_one", 64'(busy_one), 0);
        bus.a_valid = 1'b0;
        #2 rst_n = 1'b1;

        // Claim r2, then reset mid-transfer drops write and reservation
        step();
        claim_valid = 1'b1; claim_rd = 5'd2;
        step();
        claim_valid = 1'b0;
        @(negedge clk);
        chk("claim2_busy", 64'(busy_one), 1);
        step();
        bus.a_valid = 1'b1; bus.a_rd = 5'd2; bus.a_data = 64'd2500;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_regWr", 64'(bus.rf_regWr), 0);
        chk("midrst_a_ready", 64'(bus.a_ready), 0);
        chk("midrst_busy", 64'(busy_one), 0);
        bus.a_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single write from A
        step();
        bus.a_valid = 1'b1; bus.a_rd = 5'd2; bus.a_data = 64'd2500;
        @(negedge clk);
        chk("single_a_ready", 64'(bus.a_ready), 1);
        chk("single_b_ready", 64'(bus.b_ready), 0);
        expect_write(5'd2, 64'd2500);
        step();
        bus.a_valid = 1'b0;
        step();
        @(negedge clk);
        chk("single_regWr_off", 64'(bus.rf_regWr), 0);

        // Contention: A, B, A, B with back-to-back commits
        step();
        bus.a_valid = 1'b1; bus.a_rd = 5'd19; bus.a_data = 64'd2555;
        bus.b_valid = 1'b1; bus.b_rd = 5'd31; bus.b_data = 64'd2555;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_a_ready", 64'(bus.a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("cont_b_ready", 64'(bus.b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            if (i > 0) chk("cont_regWr", 64'(bus.rf_regWr), 1);
            if (i % 2 == 0) expect_write(5'd19, 64'd2555);
            else            expect_write(5'd31, 64'd2555);
            step();
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk);
        chk("cont_regWr_last", 64'(bus.rf_regWr), 1);

        // Scoreboard: claim 19, B commits 19
        rd_addr_one = 5'd19;
        step();
        claim_valid = 1'b1; claim_rd = 5'd19;
        step();
        claim_valid = 1'b0;
        @(negedge clk);
        chk("sb_claim_busy", 64'(busy_one), 1);
        step();
        bus.b_valid = 1'b1; bus.b_rd = 5'd19; bus.b_data = 64'd77;
        @(negedge clk);
        chk("sb_b_ready", 64'(bus.b_ready), 1);
        expect_write(5'd19, 64'd77);
        step();
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("sb_busy_commit_cycle", 64'(busy_one), c_BYP ? 64'd0 : 64'd1);
        step();
        @(negedge clk);
        chk("sb_busy_after_commit", 64'(busy_one), 0);

        // Claim and commit to 19 in the same cycle: claim wins
        step();
        bus.a_valid = 1'b1; bus.a_rd = 5'd19; bus.a_data = 64'd88;
        @(negedge clk);
        chk("cc_a_ready", 64'(bus.a_ready), 1);
        expect_write(5'd19, 64'd88);
        step();
        bus.a_valid = 1'b0;
        claim_valid = 1'b1; claim_rd = 5'd19;
        step();
        claim_valid = 1'b0;
        @(negedge clk);
        chk("cc_busy_stays", 64'(busy_one), 1);

        // Claim on x0 ignored
        step();
        claim_valid = 1'b1; claim_rd = 5'd0; rd_addr_two = 5'd0;
        step();
        claim_valid = 1'b0;
        @(negedge clk);
        chk("x0_claim_busy", 64'(busy_two), 0);

        // x0 write accepted but not committed
        step();
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 64'hFFFF;
        @(negedge clk);
        chk("x0_a_ready", 64'(bus.a_ready), 1);
        step();
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("x0_regWr", 64'(bus.rf_regWr), 0);

        // Stall blocks grants and holds priority (currently A)
        step();
        bus.wb_stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 64'd1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd6; bus.b_data = 64'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_a_ready", 64'(bus.a_ready), 0);
            chk("stall_b_ready", 64'(bus.b_ready), 0);
            step();
        end
        bus.wb_stall = 1'b0;
        @(negedge clk);
        chk("poststall_a_ready", 64'(bus.a_ready), 1);
        chk("poststall_b_ready", 64'(bus.b_ready), 0);
        expect_write(5'd5, 64'd1);
        step();
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("poststall2_b_ready", 64'(bus.b_ready), 1);
        expect_write(5'd6, 64'd2);
        step();
        bus.b_valid = 1'b0;

        // Bypass: commit to 31 while port one reads 31, port two reads 2
        rd_addr_one = 5'd31; rd_addr_two = 5'd2;
        step();
        claim_valid = 1'b1; claim_rd = 5'd31;
        step();
        claim_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_rd = 5'd31; bus.b_data = 64'd2555;
        @(negedge clk);
        chk("byp_b_ready", 64'(bus.b_ready), 1);
        expect_write(5'd31, 64'd2555);
        step();
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("byp_hit_one", 64'(byp_hit_one), c_BYP ? 64'd1 : 64'd0);
        chk("byp_data_one", byp_data_one, c_BYP ? 64'd2555 : 64'd0);
        chk("byp_busy_one", 64'(busy_one), c_BYP ? 64'd0 : 64'd1);
        chk("byp_hit_two", 64'(byp_hit_two), 0);
        chk("byp_data_two", byp_data_two, 0);
        chk("byp_busy_two", 64'(busy_two), 0);
        step();
        @(negedge clk);
        chk("byp_busy_after", 64'(busy_one), 0);
        chk("byp_hit_after", 64'(byp_hit_one), 0);

        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
